// File: rtl/fifo_scoreboard_pkg.sv
// ==== fifo_scoreboard_pkg : shared types, widths and helpers for the scoreboard ====
// ==== rev 1.0 ====
`default_nettype none

package fifo_scoreboard_pkg;

    typedef enum logic [0:0] {
        PASS = 1'b0,
        FAIL = 1'b1
    } sb_state_t;

    localparam int CNT_W      = 32;
    localparam int MISMATCH_W = 16;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        logic [CNT_W-1:0] one;
        one = 1;
        return (value >= limit) ? limit : value + one;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_scoreboard_check_if.sv
// ==== fifo_scoreboard_check_if : event inputs and status outputs of the scoreboard ====
// ==== rev 1.0 ====
`default_nettype none

interface fifo_scoreboard_check_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             i_cg;
    logic             i_clear;
    logic             i_pushed;
    logic [WIDTH-1:0] i_wdata;
    logic             i_popped;
    logic [WIDTH-1:0] i_rdata;

    logic [31:0]      o_nPushed;
    logic [31:0]      o_nPopped;
    logic [15:0]      o_nMismatch;
    logic [OCC_W-1:0] o_occupancy;
    logic [WIDTH-1:0] o_expected;
    logic [31:0]      o_firstBadIdx;
    logic [WIDTH-1:0] o_firstBadGot;
    logic [WIDTH-1:0] o_firstBadExp;
    logic             o_errMismatch;
    logic             o_errUnderflow;
    logic             o_errOverflow;
    logic             o_errTimeout;
    logic             o_pass;

    modport master (
        output i_cg, i_clear, i_pushed, i_wdata, i_popped, i_rdata,
        input  o_nPushed, o_nPopped, o_nMismatch, o_occupancy, o_expected,
               o_firstBadIdx, o_firstBadGot, o_firstBadExp,
               o_errMismatch, o_errUnderflow, o_errOverflow, o_errTimeout, o_pass
    );

    modport slave (
        input  i_cg, i_clear, i_pushed, i_wdata, i_popped, i_rdata,
        output o_nPushed, o_nPopped, o_nMismatch, o_occupancy, o_expected,
               o_firstBadIdx, o_firstBadGot, o_firstBadExp,
               o_errMismatch, o_errUnderflow, o_errOverflow, o_errTimeout, o_pass
    );

endinterface

`default_nettype wire

// File: rtl/scoreboard_queue.sv
// ==== scoreboard_queue : flop circular buffer holding expected FIFO data ====
// ==== rev 1.0 ====
`default_nettype none

module scoreboard_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clear,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   occupancy
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // push/pop arrive pre-qualified: the caller never pushes into a full queue
    // without a same-cycle pop, nor pops an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head      = empty ? '0 : mem[rptr[AW-1:0]];
    assign occupancy = wptr - rptr;

endmodule

`default_nettype wire

// File: rtl/fifo_scoreboard_check.sv
// ==== fifo_scoreboard_check : in-order push/pop checker for a single-clock FIFO ====
// ==== rev 1.0 ====
`default_nettype none

module fifo_scoreboard_check
    import fifo_scoreboard_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input wire logic               i_clk,
    input wire logic               i_rst,
    fifo_scoreboard_check_if.slave bus
);
    localparam int                    AW           = $clog2(DEPTH);
    localparam int                    OW           = AW + 1;
    localparam logic [CNT_W-1:0]      CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]      TIMEOUT_LIM  = CNT_W'(TIMEOUT);
    localparam logic [MISMATCH_W-1:0] MISMATCH_ONE = 1;

    logic             q_push;
    logic             q_pop;
    logic [WIDTH-1:0] q_head;
    logic             q_full;
    logic             q_empty;
    logic [OW-1:0]    q_occ;

    logic             clr;
    logic             act;
    logic             bypass;
    logic             compare_valid;
    logic [WIDTH-1:0] exp_data;
    logic             mism;
    logic             underflow;
    logic             overflow;
    logic             timeout_hit;
    logic             any_err;
    logic [OW-1:0]    occ_next;

    sb_state_t        state;
    sb_state_t        state_next;

    logic [CNT_W-1:0]      n_pushed;
    logic [CNT_W-1:0]      n_popped;
    logic [MISMATCH_W-1:0] n_mismatch;
    logic [CNT_W-1:0]      tcnt;
    logic [CNT_W-1:0]      first_idx;
    logic [WIDTH-1:0]      first_got;
    logic [WIDTH-1:0]      first_exp;
    logic                  err_mismatch;
    logic                  err_underflow;
    logic                  err_overflow;
    logic                  err_timeout;
    logic                  pass;

    assign clr = bus.i_cg && bus.i_clear;
    assign act = bus.i_cg && !bus.i_clear;

    // An empty queue with a same-cycle push and pop compares straight against wdata.
    assign bypass        = bus.i_popped && bus.i_pushed && q_empty;
    assign q_pop         = act && bus.i_popped && !q_empty;
    assign q_push        = act && bus.i_pushed && !bypass && (!q_full || bus.i_popped);
    assign compare_valid = act && bus.i_popped && (!q_empty || bus.i_pushed);
    assign exp_data      = q_empty ? bus.i_wdata : q_head;
    assign mism          = compare_valid && (bus.i_rdata != exp_data);
    assign underflow     = act && bus.i_popped && q_empty && !bus.i_pushed;
    assign overflow      = act && bus.i_pushed && q_full && !bus.i_popped;
    assign timeout_hit   = act && (TIMEOUT != 0) && (tcnt >= TIMEOUT_LIM);
    assign any_err       = mism || underflow || overflow || timeout_hit;
    assign occ_next      = q_occ + OW'(q_push) - OW'(q_pop);

    scoreboard_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .clear     (clr),
        .push      (q_push),
        .pop       (q_pop),
        .wdata     (bus.i_wdata),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .occupancy (q_occ)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)     state <= PASS;
        else if (clr)   state <= PASS;
        else if (act)   state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PASS:    if (any_err) state_next = FAIL;
            FAIL:    state_next = FAIL;
            default: state_next = PASS;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            n_pushed      <= '0;
            n_popped      <= '0;
            n_mismatch    <= '0;
            tcnt          <= '0;
            first_idx     <= '0;
            first_got     <= '0;
            first_exp     <= '0;
            err_mismatch  <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_timeout   <= 1'b0;
            pass          <= 1'b0;
        end else if (clr) begin
            n_pushed      <= '0;
            n_popped      <= '0;
            n_mismatch    <= '0;
            tcnt          <= '0;
            first_idx     <= '0;
            first_got     <= '0;
            first_exp     <= '0;
            err_mismatch  <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_timeout   <= 1'b0;
            pass          <= 1'b0;
        end else if (act) begin
            if (bus.i_pushed) n_pushed <= sat_inc(n_pushed, CNT_MAX);
            if (bus.i_popped) n_popped <= sat_inc(n_popped, CNT_MAX);
            if (mism) begin
                if (n_mismatch != '1) n_mismatch <= n_mismatch + MISMATCH_ONE;
                // Only the first offender is captured; later ones just count.
                if (!err_mismatch) begin
                    err_mismatch <= 1'b1;
                    first_idx    <= n_popped;
                    first_got    <= bus.i_rdata;
                    first_exp    <= exp_data;
                end
            end
            if (underflow)   err_underflow <= 1'b1;
            if (overflow)    err_overflow  <= 1'b1;
            if (timeout_hit) err_timeout   <= 1'b1;
            if (bus.i_popped || q_empty) tcnt <= '0;
            else                         tcnt <= sat_inc(tcnt, CNT_MAX);
            pass <= (state_next == PASS) && (occ_next == '0);
        end
    end

    assign bus.o_nPushed      = n_pushed;
    assign bus.o_nPopped      = n_popped;
    assign bus.o_nMismatch    = n_mismatch;
    assign bus.o_occupancy    = q_occ;
    assign bus.o_expected     = q_head;
    assign bus.o_firstBadIdx  = first_idx;
    assign bus.o_firstBadGot  = first_got;
    assign bus.o_firstBadExp  = first_exp;
    assign bus.o_errMismatch  = err_mismatch;
    assign bus.o_errUnderflow = err_underflow;
    assign bus.o_errOverflow  = err_overflow;
    assign bus.o_errTimeout   = err_timeout;
    assign bus.o_pass         = pass;

endmodule

`default_nettype wire

// File: tb/tb_fifo_scoreboard_check.sv
// ==== tb_fifo_scoreboard_check : self-checking bench for fifo_scoreboard_check ====
// ==== rev 1.0 ====
`default_nettype none

module tb_fifo_scoreboard_check;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 10;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] sb_q [$];

    fifo_scoreboard_check_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_scoreboard_check #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the head seen by a pop is compared against the bench queue.
    task automatic drive(input bit push, input logic [WIDTH-1:0] wd,
                         input bit pop, input logic [WIDTH-1:0] rd);
        bit was_empty;
        was_empty = (sb_q.size() == 0);
        if (pop && !was_empty) begin
            check_val("head", 32'(bus.o_expected), 32'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (push && !(pop && was_empty) && sb_q.size() < DEPTH) sb_q.push_back(wd);
        bus.i_pushed = push;
        bus.i_wdata  = wd;
        bus.i_popped = pop;
        bus.i_rdata  = rd;
        @(posedge clk);
        #1;
        bus.i_pushed = 1'b0;
        bus.i_popped = 1'b0;
        bus.i_wdata  = '0;
        bus.i_rdata  = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_clear();
        bus.i_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clear = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.i_cg     = 1'b1;
        bus.i_clear  = 1'b0;
        bus.i_pushed = 1'b0;
        bus.i_popped = 1'b0;
        bus.i_wdata  = '0;
        bus.i_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_npushed", bus.o_nPushed, 0);
        check_val("rst_occ", 32'(bus.o_occupancy), 0);
        check_val("rst_pass", 32'(bus.o_pass), 0);
        check_val("rst_flags", {28'd0, bus.o_errMismatch, bus.o_errUnderflow,
                                bus.o_errOverflow, bus.o_errTimeout}, 0);
        rst_n = 1'b1;

        // In-order traffic
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h11 + 8'(i), 1'b0, '0);
        check_val("burst_occ", 32'(bus.o_occupancy), 32'(sb_q.size()));
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 8'h11 + 8'(i));
        check_val("inorder_npushed", bus.o_nPushed, 5);
        check_val("inorder_npopped", bus.o_nPopped, 5);
        check_val("inorder_nmism", 32'(bus.o_nMismatch), 0);
        check_val("inorder_pass", 32'(bus.o_pass), 1);
        check_val("inorder_occ", 32'(bus.o_occupancy), 0);

        // First mismatch capture
        do_clear();
        drive(1'b1, 8'hA0, 1'b0, '0);
        drive(1'b1, 8'hA1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 8'hA0);
        drive(1'b0, '0, 1'b1, 8'hFF);
        check_val("mm_count", 32'(bus.o_nMismatch), 1);
        check_val("mm_flag", 32'(bus.o_errMismatch), 1);
        check_val("mm_idx", bus.o_firstBadIdx, 1);
        check_val("mm_got", 32'(bus.o_firstBadGot), 32'h0FF);
        check_val("mm_exp", 32'(bus.o_firstBadExp), 32'h0A1);
        check_val("mm_pass", 32'(bus.o_pass), 0);

        // Underflow and bypass
        do_clear();
        drive(1'b0, '0, 1'b1, 8'h77);
        check_val("uf_flag", 32'(bus.o_errUnderflow), 1);
        check_val("uf_nmism", 32'(bus.o_nMismatch), 0);
        do_clear();
        drive(1'b1, 8'h3C, 1'b1, 8'h3C);
        check_val("byp_errs", {29'd0, bus.o_errMismatch, bus.o_errUnderflow, bus.o_errOverflow}, 0);
        check_val("byp_occ", 32'(bus.o_occupancy), 0);
        check_val("byp_pass", 32'(bus.o_pass), 1);
        drive(1'b1, 8'h3C, 1'b1, 8'h3D);
        check_val("byp_mm_count", 32'(bus.o_nMismatch), 1);
        check_val("byp_mm_exp", 32'(bus.o_firstBadExp), 32'h03C);
        check_val("byp_mm_got", 32'(bus.o_firstBadGot), 32'h03D);

        // Overflow at DEPTH, then full with simultaneous pop
        do_clear();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 8'(i), 1'b0, '0);
        check_val("ovf_flag", 32'(bus.o_errOverflow), 1);
        check_val("ovf_occ", 32'(bus.o_occupancy), DEPTH);
        check_val("ovf_npushed", bus.o_nPushed, DEPTH + 1);
        do_clear();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0, '0);
        drive(1'b1, 8'h40, 1'b1, 8'h20);
        check_val("fullpop_ovf", 32'(bus.o_errOverflow), 0);
        check_val("fullpop_occ", 32'(bus.o_occupancy), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            v = sb_q[0];
            drive(1'b0, '0, 1'b1, v);
        end
        check_val("drain_occ", 32'(bus.o_occupancy), 0);
        check_val("drain_nmism", 32'(bus.o_nMismatch), 0);
        check_val("drain_expected", 32'(bus.o_expected), 0);

        // Timeout edge
        do_clear();
        drive(1'b1, 8'h55, 1'b0, '0);
        idle(TIMEOUT);
        check_val("to_before", 32'(bus.o_errTimeout), 0);
        idle(1);
        check_val("to_after", 32'(bus.o_errTimeout), 1);

        // Clock gate freezes the timeout and ignores inputs
        do_clear();
        drive(1'b1, 8'h56, 1'b0, '0);
        idle(5);
        bus.i_cg     = 1'b0;
        bus.i_pushed = 1'b1;
        bus.i_wdata  = 8'h99;
        repeat (20) @(posedge clk);
        #1;
        bus.i_pushed = 1'b0;
        bus.i_cg     = 1'b1;
        check_val("cg_npushed", bus.o_nPushed, 1);
        check_val("cg_to", 32'(bus.o_errTimeout), 0);
        idle(TIMEOUT - 5);
        check_val("cg_to_edge", 32'(bus.o_errTimeout), 0);
        idle(1);
        check_val("cg_to_set", 32'(bus.o_errTimeout), 1);
        check_val("cg_to_pass", 32'(bus.o_pass), 0);

        // Clear after error
        do_clear();
        check_val("clr_flags", {28'd0, bus.o_errMismatch, bus.o_errUnderflow,
                                bus.o_errOverflow, bus.o_errTimeout}, 0);
        check_val("clr_npushed", bus.o_nPushed, 0);
        check_val("clr_occ", 32'(bus.o_occupancy), 0);
        idle(1);
        check_val("clr_pass", 32'(bus.o_pass), 1);

        // Asynchronous reset mid-burst
        drive(1'b1, 8'h71, 1'b0, '0);
        drive(1'b1, 8'h72, 1'b0, '0);
        bus.i_pushed = 1'b1;
        bus.i_wdata  = 8'h73;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_npushed", bus.o_nPushed, 0);
        check_val("arst_occ", 32'(bus.o_occupancy), 0);
        check_val("arst_expected", 32'(bus.o_expected), 0);
        bus.i_pushed = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_scoreboard_check.md
Name: fifo_scoreboard_check

Overview:
Synthesizable in-simulation scoreboard that sits directly downstream of a single-clock FIFO-like DUT. It consumes the DUT's push events (wdata accepted) and pop events (rdata accepted) and keeps an ordered reference queue of expected data. On every pop it checks in-order equality and raises sticky error flags and counters. It replaces offline comparison of pushed/popped logs for non-CDC configurations.

Parameters:
WIDTH, 8, data width in bits (1..32).
DEPTH, 16, reference queue entries; power of 2, >= 2, must be >= DUT capacity plus 1.
TIMEOUT, 1000, cycles with a non-empty queue and no pop before o_errTimeout sets; 0 disables the check.

Ports:
i_clk  input  1  clock, same clock as the DUT.
i_rst  input  1  reset, asynchronous, active-low.
i_cg  input  1  clockgate; when low all state holds and all inputs are ignored.
i_clear  input  1  synchronous clear of queue, counters and flags (same effect as reset).
i_pushed  input  1  DUT accepted i_wdata this cycle (cg && valid && ready).
i_wdata  input  WIDTH  data pushed into the DUT.
i_popped  input  1  DUT delivered i_rdata this cycle.
i_rdata  input  WIDTH  data popped from the DUT.
o_nPushed  output  32  count of pushes, saturating.
o_nPopped  output  32  count of pops, saturating.
o_nMismatch  output  16  count of mismatched pops, saturating.
o_occupancy  output  $clog2(DEPTH)+1  entries held in the reference queue.
o_expected  output  WIDTH  head of the reference queue (0 when empty).
o_firstBadIdx  output  32  value of o_nPopped at the first mismatch.
o_firstBadGot  output  WIDTH  i_rdata at the first mismatch.
o_firstBadExp  output  WIDTH  expected data at the first mismatch.
o_errMismatch, o_errUnderflow, o_errOverflow, o_errTimeout  output  1 each  sticky error flags.
o_pass  output  1  high when in PASS state and occupancy == 0.

Behaviour:
- Reset and i_clear: all outputs 0, queue empty, state PASS. i_clear takes priority over push/pop in the same cycle.
- All updates occur on the rising edge of i_clk, and only when i_cg=1.
- Reference queue: circular buffer of flops with wptr/rptr one bit wider than log2(DEPTH). Full when the MSBs differ and the low bits are equal.
- Push: the entry is written at wptr and wptr increments.
  - If the queue is full and there is no simultaneous pop: set o_errOverflow, drop the data, hold wptr.
  - Full with a simultaneous pop: push is accepted.
- Pop, queue non-empty: compare i_rdata against the head entry, then rptr increments.
- Pop, queue empty, simultaneous push: bypass. Compare i_rdata against i_wdata; occupancy stays 0.
- Pop, queue empty, no push: set o_errUnderflow. The pop is not compared.
- Mismatch: o_nMismatch increments.
  - On the first mismatch only, latch o_firstBadIdx, o_firstBadGot and o_firstBadExp, and set o_errMismatch.
- Counters saturate at all-ones and never wrap. o_firstBadIdx records the pre-increment o_nPopped.
- Timeout counter:
  - Clears on any pop or whenever the queue is empty.
  - Increments otherwise, and holds while i_cg=0.
  - When it reaches TIMEOUT, set o_errTimeout.
- State machine:
  - PASS -> FAIL on any error flag setting.
  - FAIL is absorbing until reset or i_clear.
- Outputs are registered. o_expected is combinational from the queue head.
- Latency: flags and counters reflect an event on the cycle after it.
- Asserting reset mid-operation discards queue contents immediately (asynchronous).

Decomposition:
- Package fifo_scoreboard_pkg holds:
  - state enum {PASS, FAIL};
  - counter width constants CNT_W=32 and MISMATCH_W=16;
  - a saturating-increment function.
- One natural sub-module: scoreboard_queue, the flop circular buffer providing push, pop, head, full, empty and occupancy.
- Comparison, flags, counters and the FSM stay in the top.

Test Plan:
- 5 pushes of 0x11..0x15, then 5 in-order pops of the same values -> nPushed=5, nPopped=5, nMismatch=0, o_pass=1, occupancy=0.
- Push 0xA0, 0xA1; pop 0xA0, 0xFF -> nMismatch=1, errMismatch=1, firstBadIdx=1, firstBadGot=0xFF, firstBadExp=0xA1, o_pass=0.
- Pop on an empty queue with no push -> errUnderflow=1, nMismatch=0. Same-cycle push 0x3C and pop 0x3C while empty -> no error, occupancy stays 0.
- DEPTH=16: 17 pushes with no pop -> errOverflow=1 and occupancy=16. A 17th push with a simultaneous pop -> no overflow.
- TIMEOUT=10: push 1 entry, then no pop for 10 cycles -> errTimeout set on cycle 11. Holding i_cg=0 for 20 cycles -> timeout does not advance.
- i_clear asserted after an error -> all flags and counters 0, state PASS. Async reset asserted mid-burst -> outputs 0 without waiting for a clock edge.
